// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronize and debounce slide switches, emit clean levels and edge strobes
// ports: clk; rst (sync, active-high); sw_raw async switch levels;
//        sw_clean debounced levels; sw_rise/sw_fall per-bit 1-cycle edge strobes;
//        sw_changed 1-cycle strobe when any bit rises or falls
module switch_debouncer #(
  parameter int WIDTH   = 4,
  parameter int CNT_MAX = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);
  localparam int CW = $clog2(CNT_MAX + 1);
  logic [WIDTH-1:0] sync1_q, sync2_q, clean_q, clean_d, rise_q, fall_q, done;
  logic             changed_q;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  // a bit counts only while its synchronized level disagrees with the clean level;
  // agreement (stable or glitch ended) parks the counter at zero
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    assign done[b]  = (sync2_q[b] != clean_q[b]) && (cnt_q[b] == CW'(CNT_MAX - 1));
    assign cnt_d[b] = (sync2_q[b] != clean_q[b] && !done[b]) ? cnt_q[b] + CW'(1) : '0;
  end
  assign clean_d = clean_q ^ done;
  always_ff @(posedge clk) begin
    sync1_q   <= rst ? '0 : sw_raw;
    sync2_q   <= rst ? '0 : sync1_q;
    clean_q   <= rst ? '0 : clean_d;
    rise_q    <= rst ? '0 : done & sync2_q;
    fall_q    <= rst ? '0 : done & ~sync2_q;
    changed_q <= rst ? 1'b0 : |done;
    for (int i = 0; i < WIDTH; i++) cnt_q[i] <= rst ? '0 : cnt_d[i];
  end
  assign sw_clean   = clean_q;
  assign sw_rise    = rise_q;
  assign sw_fall    = fall_q;
  assign sw_changed = changed_q;
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed stimulus with a sample-window reference model and scoreboard
module tb_switch_debouncer;
  localparam int W  = 4;
  localparam int CM = 4;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_clean, sw_rise, sw_fall;
  logic         sw_changed;
  switch_debouncer #(.WIDTH(W), .CNT_MAX(CM)) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .sw_clean(sw_clean),
    .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_changed(sw_changed)
  );
  always #5 clk = ~clk;
  typedef struct {logic [W-1:0] c, r, f; logic ch;} exp_t;
  exp_t         sb[$];
  logic [W-1:0] samp [CM+1];
  logic [W-1:0] m_clean = '0;
  int           n_chk = 0, n_pass = 0, n_rise3 = 0;
  string        tag = "init";
  task automatic chk(input string t, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %b expected %b", t, obs, exp);
  endtask
  // samp[k] holds raw as sampled k+1 edges ago; a bit's clean level flips once the
  // CM samples feeding the counter (two edges of synchronizer lag) all disagree with it
  task automatic step(input logic [W-1:0] raw, input logic r);
    logic [W-1:0] nc, diff;
    exp_t e;
    sw_raw = raw;
    rst = r;
    if (r) begin
      nc = '0;
      e = '{c: '0, r: '0, f: '0, ch: 1'b0};
      for (int k = 0; k <= CM; k++) samp[k] = '0;
    end else begin
      diff = '1;
      for (int k = 1; k <= CM; k++) diff &= samp[k] ^ m_clean;
      nc = m_clean ^ diff;
      e = '{c: nc, r: nc & ~m_clean, f: ~nc & m_clean, ch: |diff};
      for (int k = CM; k >= 1; k--) samp[k] = samp[k-1];
      samp[0] = raw;
    end
    m_clean = nc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, " clean"}, sw_clean, e.c);
    chk({tag, " rise"}, sw_rise, e.r);
    chk({tag, " fall"}, sw_fall, e.f);
    chk({tag, " changed"}, {3'b0, sw_changed}, {3'b0, e.ch});
    if (sw_rise[3]) n_rise3++;
  endtask
  initial begin
    for (int k = 0; k <= CM; k++) samp[k] = '0;
    tag = "t1_reset";
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    tag = "t1_idle";
    for (int i = 0; i < 10; i++) step(4'b0000, 1'b0);
    tag = "t2_rise";
    for (int i = 1; i <= 5; i++) step(4'b0001, 1'b0);
    chk("t2_edge5_clean", sw_clean, 4'b0000);
    step(4'b0001, 1'b0);
    chk("t2_edge6_clean", sw_clean, 4'b0001);
    chk("t2_edge6_rise", sw_rise, 4'b0001);
    chk("t2_edge6_changed", {3'b0, sw_changed}, 4'b0001);
    step(4'b0001, 1'b0);
    chk("t2_edge7_rise", sw_rise, 4'b0000);
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b0);
    tag = "t3_glitch";
    for (int i = 0; i < 3; i++) step(4'b0011, 1'b0);
    for (int i = 0; i < 8; i++) step(4'b0001, 1'b0);
    chk("t3_clean", sw_clean, 4'b0001);
    tag = "t4_bounce";
    n_rise3 = 0;
    for (int i = 0; i < 20; i++) step(((i / 2) % 2 == 0) ? 4'b1001 : 4'b0001, 1'b0);
    for (int i = 1; i <= 5; i++) step(4'b1001, 1'b0);
    chk("t4_edge5_clean", sw_clean, 4'b0001);
    step(4'b1001, 1'b0);
    chk("t4_edge6_clean", sw_clean, 4'b1001);
    for (int i = 0; i < 4; i++) step(4'b1001, 1'b0);
    chk("t4_rise3_count", 4'(n_rise3), 4'd1);
    tag = "t5_prep";
    for (int i = 0; i < 8; i++) step(4'b0011, 1'b0);
    chk("t5_prep_clean", sw_clean, 4'b0011);
    tag = "t5_swap";
    for (int i = 1; i <= 6; i++) step(4'b1100, 1'b0);
    chk("t5_clean", sw_clean, 4'b1100);
    chk("t5_rise", sw_rise, 4'b1100);
    chk("t5_fall", sw_fall, 4'b0011);
    chk("t5_changed", {3'b0, sw_changed}, 4'b0001);
    step(4'b1100, 1'b0);
    chk("t5_changed_after", {3'b0, sw_changed}, 4'b0000);
    tag = "t6_prep";
    step(4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b0);
    tag = "t6_rst_mid";
    for (int i = 1; i <= 3; i++) step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    for (int i = 1; i <= 5; i++) step(4'b0100, 1'b0);
    chk("t6_edge5_clean", sw_clean, 4'b0000);
    step(4'b0100, 1'b0);
    chk("t6_edge6_clean", sw_clean, 4'b0100);
    chk("t6_edge6_rise", sw_rise, 4'b0100);
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
